// File: rtl/note_lane_scroller.sv
// rtl/note_lane_scroller.sv - N-lane note-highway scroller with play/pause/done control and optional looping
// Each lane keeps a chart copy and a shift register whose top WINDOW bits form the visible rows.
module note_lane_scroller #(
    parameter int LANES    = 2,
    parameter int SONG_LEN = 32,
    parameter int WINDOW   = 7,
    localparam int STEP_W  = $clog2(SONG_LEN + WINDOW + 1)
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       load,
    input  logic [LANES*SONG_LEN-1:0]  notes,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       scroll,
    input  logic                       loop_en,
    output logic [LANES*WINDOW-1:0]    out,
    output logic [LANES-1:0]           strike,
    output logic                       playing,
    output logic                       done,
    output logic [STEP_W-1:0]          step
);

    localparam int TOTAL = SONG_LEN + WINDOW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADED,
        S_PLAYING,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [TOTAL-1:0]    r_sh   [LANES];
    logic [SONG_LEN-1:0] r_song [LANES];
    logic [STEP_W-1:0]   r_step;
    logic                r_done;
    logic                w_advance;
    logic                w_last;

    assign w_advance = scroll && !pause;
    assign w_last    = (r_step == STEP_W'(TOTAL - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (load) begin
            w_next = S_LOADED;
        end else begin
            case (r_state)
                S_LOADED:  if (start) w_next = S_PLAYING;
                S_PLAYING: begin
                    if (pause) begin
                        w_next = S_PAUSED;
                    end else if (scroll && w_last && !loop_en) begin
                        w_next = S_DONE;
                    end
                end
                S_PAUSED:  if (!pause) w_next = S_PLAYING;
                S_DONE:    if (start) w_next = S_PLAYING;
                default:   w_next = r_state;
            endcase
        end
    end

    // Datapath: chart capture, shifting, wrap/reload and the registered done pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int l = 0; l < LANES; l++) begin
                r_sh[l]   <= '0;
                r_song[l] <= '0;
            end
            r_step <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                for (int l = 0; l < LANES; l++) begin
                    r_song[l] <= notes[l*SONG_LEN +: SONG_LEN];
                    r_sh[l]   <= {{WINDOW{1'b0}}, notes[l*SONG_LEN +: SONG_LEN]};
                end
                r_step <= '0;
            end else if (r_state == S_PLAYING && w_advance) begin
                if (w_last) begin
                    r_done <= 1'b1;
                end
                if (w_last && loop_en) begin
                    for (int l = 0; l < LANES; l++) begin
                        r_sh[l] <= {{WINDOW{1'b0}}, r_song[l]};
                    end
                    r_step <= '0;
                end else begin
                    for (int l = 0; l < LANES; l++) begin
                        r_sh[l] <= r_sh[l] << 1;
                    end
                    r_step <= r_step + 1'b1;
                end
            end else if (r_state == S_DONE && start) begin
                for (int l = 0; l < LANES; l++) begin
                    r_sh[l] <= {{WINDOW{1'b0}}, r_song[l]};
                end
                r_step <= '0;
            end
        end
    end

    // Lanes interleave within each row with lane 0 in the most significant slot.
    always_comb begin
        out    = '0;
        strike = '0;
        if (r_state != S_DONE) begin
            for (int r = 0; r < WINDOW; r++) begin
                for (int l = 0; l < LANES; l++) begin
                    out[r*LANES + (LANES-1-l)] = r_sh[l][SONG_LEN + r];
                end
            end
            for (int l = 0; l < LANES; l++) begin
                strike[l] = r_sh[l][SONG_LEN];
            end
        end
        playing = (r_state == S_PLAYING);
        done    = r_done;
        step    = r_step;
    end

endmodule
